// File: rtl/axi_slave_pkg.sv
// Shared constants and FSM state types for the AXI RAM responder.
//   BURST_*     : AXI burst type encodings accepted on AW/AR
//   RESP_*      : B/R response codes
//   wr_state_t  : write-channel FSM states
//   rd_state_t  : read-channel FSM states
//   req_code()  : response code decided at address-handshake time
package axi_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_ERR    = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

  // Unsupported burst outranks an out-of-range address.
  function automatic logic [1:0] req_code(input logic [1:0] burst, input logic in_range);
    if (burst[1])  return RESP_ERR;
    if (!in_range) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI_INF: the team's 32-bit AXI bus (five channels).
//   Ports    : CLK, RSTN (bus clock/reset, owned by the environment)
//   AW       : WR_ADDR_VALID/READY, WR_ADDR, WR_ADDR_ID, WR_ADDR_LEN, WR_ADDR_BURST
//   W        : WR_DATA_VALID/READY, WR_DATA, WR_STRB, WR_DATA_LAST
//   B        : WR_BACK_VALID/READY, WR_BACK_ID, WR_BACK_RESP
//   AR       : RD_ADDR_VALID/READY, RD_ADDR, RD_ADDR_ID, RD_ADDR_LEN, RD_ADDR_BURST
//   R        : RD_DATA_VALID/READY, RD_DATA, RD_DATA_ID, RD_DATA_RESP, RD_DATA_LAST
//   Modports : SYNC_S (responder side), SYNC_M (requester side)
interface AXI_INF #(
  parameter int ID_WIDTH = 2
) (
  input logic CLK,
  input logic RSTN
);
  logic                WR_ADDR_VALID;
  logic                WR_ADDR_READY;
  logic [31:0]         WR_ADDR;
  logic [ID_WIDTH-1:0] WR_ADDR_ID;
  logic [7:0]          WR_ADDR_LEN;
  logic [1:0]          WR_ADDR_BURST;

  logic                WR_DATA_VALID;
  logic                WR_DATA_READY;
  logic [31:0]         WR_DATA;
  logic [3:0]          WR_STRB;
  logic                WR_DATA_LAST;

  logic                WR_BACK_VALID;
  logic                WR_BACK_READY;
  logic [ID_WIDTH-1:0] WR_BACK_ID;
  logic [1:0]          WR_BACK_RESP;

  logic                RD_ADDR_VALID;
  logic                RD_ADDR_READY;
  logic [31:0]         RD_ADDR;
  logic [ID_WIDTH-1:0] RD_ADDR_ID;
  logic [7:0]          RD_ADDR_LEN;
  logic [1:0]          RD_ADDR_BURST;

  logic                RD_DATA_VALID;
  logic                RD_DATA_READY;
  logic [31:0]         RD_DATA;
  logic [ID_WIDTH-1:0] RD_DATA_ID;
  logic [1:0]          RD_DATA_RESP;
  logic                RD_DATA_LAST;

  modport SYNC_S (
    input  WR_ADDR_VALID, WR_ADDR, WR_ADDR_ID, WR_ADDR_LEN, WR_ADDR_BURST,
    output WR_ADDR_READY,
    input  WR_DATA_VALID, WR_DATA, WR_STRB, WR_DATA_LAST,
    output WR_DATA_READY,
    output WR_BACK_VALID, WR_BACK_ID, WR_BACK_RESP,
    input  WR_BACK_READY,
    input  RD_ADDR_VALID, RD_ADDR, RD_ADDR_ID, RD_ADDR_LEN, RD_ADDR_BURST,
    output RD_ADDR_READY,
    output RD_DATA_VALID, RD_DATA, RD_DATA_ID, RD_DATA_RESP, RD_DATA_LAST,
    input  RD_DATA_READY
  );

  modport SYNC_M (
    input  CLK, RSTN,
    output WR_ADDR_VALID, WR_ADDR, WR_ADDR_ID, WR_ADDR_LEN, WR_ADDR_BURST,
    input  WR_ADDR_READY,
    output WR_DATA_VALID, WR_DATA, WR_STRB, WR_DATA_LAST,
    input  WR_DATA_READY,
    input  WR_BACK_VALID, WR_BACK_ID, WR_BACK_RESP,
    output WR_BACK_READY,
    output RD_ADDR_VALID, RD_ADDR, RD_ADDR_ID, RD_ADDR_LEN, RD_ADDR_BURST,
    input  RD_ADDR_READY,
    input  RD_DATA_VALID, RD_DATA, RD_DATA_ID, RD_DATA_RESP, RD_DATA_LAST,
    output RD_DATA_READY
  );

endinterface

// File: rtl/axi_ram_slave_mem.sv
// Simple dual-port word RAM: one byte-enabled write port, one synchronous
// read port. A same-cycle read of the word being written returns old data.
//   clk   : clock
//   we/be : write enable, per-byte enables
//   waddr/wdata : write word index/data
//   raddr/rdata : read word index, registered read data
// Contents are not reset.
module axi_ram_slave_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI responder backed by on-chip word RAM. Independent
// write (AW/W/B) and read (AR/R) FSMs, FIXED/INCR bursts up to 256 beats,
// one outstanding burst per direction, IDs echoed, errors via RESP.
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   S   : AXI_INF.SYNC_S responder port
module axi_ram_slave
  import axi_slave_pkg::*;
#(
  parameter int          ID_WIDTH    = 2,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic    CLK,
  input logic    RST,
  AXI_INF.SYNC_S S
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

  wr_state_t           w_state, w_next;
  rd_state_t           r_state, r_next;
  logic                live;
  logic [ID_WIDTH-1:0] w_id, r_id;
  logic [IDX_W-1:0]    w_idx, r_idx, r_idx_next, r_addr;
  logic [7:0]          w_len, w_cnt, r_len, r_cnt;
  logic [1:0]          w_burst, r_burst, w_code, r_code;
  logic [31:0]         aw_off, ar_off, ram_q;
  logic                aw_hs, w_hs, ar_hs, r_hs, w_final, r_final, mem_we;

  assign aw_off     = S.WR_ADDR - BASE_ADDR;
  assign ar_off     = S.RD_ADDR - BASE_ADDR;
  assign aw_hs      = (w_state == W_IDLE) && live && S.WR_ADDR_VALID;
  assign w_hs       = (w_state == W_DATA) && S.WR_DATA_VALID;
  assign ar_hs      = (r_state == R_IDLE) && live && S.RD_ADDR_VALID;
  assign r_hs       = (r_state == R_DATA) && S.RD_DATA_READY;
  assign w_final    = (w_cnt == w_len);
  assign r_final    = (r_cnt == r_len);
  assign r_idx_next = (r_burst == BURST_INCR) ? r_idx + IDX_W'(1) : r_idx;
  assign mem_we     = w_hs && (w_code == RESP_OKAY);

  // 'live' holds the address READYs low for the first cycle after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      live    <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      live    <= 1'b1;
    end
  end

  always_comb begin
    w_next          = w_state;
    S.WR_ADDR_READY = 1'b0;
    S.WR_DATA_READY = 1'b0;
    S.WR_BACK_VALID = 1'b0;
    S.WR_BACK_ID    = '0;
    S.WR_BACK_RESP  = '0;
    case (w_state)
      W_IDLE: begin
        S.WR_ADDR_READY = live;
        if (aw_hs) w_next = W_DATA;
      end
      W_DATA: begin
        S.WR_DATA_READY = 1'b1;
        if (w_hs && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        S.WR_BACK_VALID = 1'b1;
        S.WR_BACK_ID    = w_id;
        S.WR_BACK_RESP  = w_code;
        if (S.WR_BACK_READY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read address follows the handshake so RD_DATA holds while stalled.
  always_comb begin
    r_next          = r_state;
    r_addr          = r_idx;
    S.RD_ADDR_READY = 1'b0;
    S.RD_DATA_VALID = 1'b0;
    S.RD_DATA       = '0;
    S.RD_DATA_ID    = '0;
    S.RD_DATA_RESP  = '0;
    S.RD_DATA_LAST  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S.RD_ADDR_READY = live;
        if (ar_hs) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        S.RD_DATA_VALID = 1'b1;
        S.RD_DATA       = (r_code == RESP_OKAY) ? ram_q : '0;
        S.RD_DATA_ID    = r_id;
        S.RD_DATA_RESP  = r_code;
        S.RD_DATA_LAST  = r_final;
        if (S.RD_DATA_READY) begin
          r_addr = r_idx_next;
          if (r_final) r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_id <= '0; w_idx <= '0; w_len <= '0; w_burst <= '0; w_code <= '0; w_cnt <= '0;
    end else begin
      if (aw_hs) begin
        w_id    <= S.WR_ADDR_ID;
        w_idx   <= IDX_W'(aw_off >> 2);
        w_len   <= S.WR_ADDR_LEN;
        w_burst <= S.WR_ADDR_BURST;
        w_code  <= req_code(S.WR_ADDR_BURST, aw_off < SPAN);
        w_cnt   <= '0;
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
        if (w_burst == BURST_INCR) w_idx <= w_idx + IDX_W'(1);
        // Beat count ends the burst; a LAST mismatch only taints the response.
        if (S.WR_DATA_LAST != w_final) w_code <= RESP_ERR;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_id <= '0; r_idx <= '0; r_len <= '0; r_burst <= '0; r_code <= '0; r_cnt <= '0;
    end else begin
      if (ar_hs) begin
        r_id    <= S.RD_ADDR_ID;
        r_idx   <= IDX_W'(ar_off >> 2);
        r_len   <= S.RD_ADDR_LEN;
        r_burst <= S.RD_ADDR_BURST;
        r_code  <= req_code(S.RD_ADDR_BURST, ar_off < SPAN);
        r_cnt   <= '0;
      end
      if (r_hs) begin
        r_cnt <= r_cnt + 8'd1;
        r_idx <= r_idx_next;
      end
    end
  end

  axi_ram_slave_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk  (CLK),
    .we   (mem_we),
    .be   (S.WR_STRB),
    .waddr(w_idx),
    .wdata(S.WR_DATA),
    .raddr(r_addr),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed testbench for axi_ram_slave: reset values, INCR/FIXED bursts,
// byte strobes, range and burst errors, LAST mismatch, read backpressure,
// mid-burst reset, and concurrent read/write throughput.
module tb_axi_ram_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [1:0]  FIX  = 2'b00;
  localparam logic [1:0]  INC  = 2'b01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rstn;
  assign rstn = ~rst;
  always #5 clk = ~clk;

  AXI_INF #(.ID_WIDTH(2)) bus (.CLK(clk), .RSTN(rstn));

  axi_ram_slave #(
    .ID_WIDTH   (2),
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (BASE)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .S  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {18'd0, bus.WR_ADDR_READY, bus.WR_DATA_READY, bus.WR_BACK_VALID, bus.WR_BACK_ID,
            bus.WR_BACK_RESP, bus.RD_ADDR_READY, bus.RD_DATA_VALID, bus.RD_DATA_LAST,
            bus.RD_DATA_ID, bus.RD_DATA_RESP, bus.RD_DATA};
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic aw_send(input logic [31:0] addr, input logic [1:0] id, input logic [7:0] len, input logic [1:0] burst);
    int n;
    n = 0;
    bus.WR_ADDR_VALID = 1'b1; bus.WR_ADDR = addr; bus.WR_ADDR_ID = id;
    bus.WR_ADDR_LEN = len; bus.WR_ADDR_BURST = burst;
    while (bus.WR_ADDR_READY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("aw_accept", 64'(n < 50), 64'h1);
    @(negedge clk);
    bus.WR_ADDR_VALID = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [1:0] id, input logic [7:0] len, input logic [1:0] burst);
    int n;
    n = 0;
    bus.RD_ADDR_VALID = 1'b1; bus.RD_ADDR = addr; bus.RD_ADDR_ID = id;
    bus.RD_ADDR_LEN = len; bus.RD_ADDR_BURST = burst;
    while (bus.RD_ADDR_READY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("ar_accept", 64'(n < 50), 64'h1);
    @(negedge clk);
    bus.RD_ADDR_VALID = 1'b0;
  endtask

  // Beat i carries first + i*step; LAST is driven high only on beat last_at.
  task automatic w_send(input logic [31:0] first, input logic [31:0] step, input int beats,
                        input logic [3:0] strb, input int last_at, output int stalls);
    int n;
    stalls = 0;
    for (int i = 0; i < beats; i++) begin
      n = 0;
      bus.WR_DATA_VALID = 1'b1; bus.WR_DATA = first + 32'(i) * step;
      bus.WR_STRB = strb; bus.WR_DATA_LAST = (i == last_at);
      while (bus.WR_DATA_READY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      stalls += n;
      check("w_accept", 64'(n < 50), 64'h1);
      @(negedge clk);
    end
    bus.WR_DATA_VALID = 1'b0; bus.WR_DATA_LAST = 1'b0;
  endtask

  task automatic b_get(input logic [1:0] eid, input logic [1:0] eresp);
    int n;
    n = 0;
    bus.WR_BACK_READY = 1'b1;
    while (bus.WR_BACK_VALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("b_valid", 64'(bus.WR_BACK_VALID), 64'h1);
    check("b_id", 64'(bus.WR_BACK_ID), 64'(eid));
    check("b_resp", 64'(bus.WR_BACK_RESP), 64'(eresp));
    @(negedge clk);
    bus.WR_BACK_READY = 1'b0;
  endtask

  // RD_DATA_READY follows pat cyclically; every cycle with VALID high is
  // checked against the pending beat, so a payload change under stall fails.
  task automatic r_get(input logic [31:0] first, input logic [31:0] step, input int beats,
                       input int last_idx, input logic [1:0] eresp, input logic [1:0] eid,
                       input logic [15:0] pat, output int gaps);
    int c, n;
    logic [31:0] ed;
    c = 0; gaps = 0;
    for (int i = 0; i < beats; i++) begin
      ed = (eresp == 2'b00) ? first + 32'(i) * step : 32'h0;
      n = 0;
      forever begin
        bus.RD_DATA_READY = pat[c % 16];
        c++;
        if (bus.RD_DATA_VALID === 1'b1) begin
          check("r_data", 64'(bus.RD_DATA), 64'(ed));
          check("r_resp", 64'(bus.RD_DATA_RESP), 64'(eresp));
          check("r_last", 64'(bus.RD_DATA_LAST), 64'(i == last_idx));
          check("r_id", 64'(bus.RD_DATA_ID), 64'(eid));
        end else if (i > 0) gaps++;
        if ((bus.RD_DATA_VALID === 1'b1 && bus.RD_DATA_READY) || n >= 60) break;
        @(negedge clk);
        n++;
      end
      check("r_beat", 64'(n < 60), 64'h1);
      @(negedge clk);
    end
    bus.RD_DATA_READY = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g, wst, rgp;
    bus.WR_ADDR_VALID = 0; bus.WR_ADDR = '0; bus.WR_ADDR_ID = '0; bus.WR_ADDR_LEN = '0; bus.WR_ADDR_BURST = '0;
    bus.WR_DATA_VALID = 0; bus.WR_DATA = '0; bus.WR_STRB = '0; bus.WR_DATA_LAST = 0; bus.WR_BACK_READY = 0;
    bus.RD_ADDR_VALID = 0; bus.RD_ADDR = '0; bus.RD_ADDR_ID = '0; bus.RD_ADDR_LEN = '0; bus.RD_ADDR_BURST = '0;
    bus.RD_DATA_READY = 0;

    // Reset: all outputs low during reset and in the first cycle after release.
    bus.RD_ADDR_VALID = 1'b1; bus.WR_ADDR_VALID = 1'b1;
    repeat (3) @(negedge clk);
    check("outs_in_reset", outs(), 64'h0);
    rst = 1'b0;
    #1 check("outs_after_release", outs(), 64'h0);
    bus.RD_ADDR_VALID = 1'b0; bus.WR_ADDR_VALID = 1'b0;
    @(negedge clk);
    check("awready_up", 64'(bus.WR_ADDR_READY), 64'h1);
    check("arready_up", 64'(bus.RD_ADDR_READY), 64'h1);

    // INCR write of 1..4 at BASE+0x10, then read it back.
    aw_send(BASE + 32'h10, 2'd2, 8'd3, INC);
    check("wready_t1", 64'(bus.WR_DATA_READY), 64'h1);
    w_send(32'd1, 32'd1, 4, 4'hF, 3, wst);
    check("bvalid_after_last", 64'(bus.WR_BACK_VALID), 64'h1);
    b_get(2'd2, 2'b00);
    check("awready_after_b", 64'(bus.WR_ADDR_READY), 64'h1);
    ar_send(BASE + 32'h10, 2'd1, 8'd3, INC);
    check("rvalid_t1", 64'(bus.RD_DATA_VALID), 64'h0);
    @(negedge clk);
    check("rvalid_t2", 64'(bus.RD_DATA_VALID), 64'h1);
    r_get(32'd1, 32'd1, 4, 3, 2'b00, 2'd1, 16'hFFFF, g);
    check("arready_after_r", 64'(bus.RD_ADDR_READY), 64'h1);

    // Byte strobes.
    aw_send(BASE + 32'h40, 2'd0, 8'd0, INC);
    w_send(32'hAABBCCDD, 32'd0, 1, 4'hF, 0, wst);
    b_get(2'd0, 2'b00);
    aw_send(BASE + 32'h40, 2'd0, 8'd0, INC);
    w_send(32'h11223344, 32'd0, 1, 4'b0101, 0, wst);
    b_get(2'd0, 2'b00);
    ar_send(BASE + 32'h40, 2'd3, 8'd0, INC);
    r_get(32'hAA22CC44, 32'd0, 1, 0, 2'b00, 2'd3, 16'hFFFF, g);

    // Out of range: index would alias word 0, which must stay intact.
    aw_send(BASE, 2'd0, 8'd0, INC);
    w_send(32'hCAFEF00D, 32'd0, 1, 4'hF, 0, wst);
    b_get(2'd0, 2'b00);
    ar_send(BASE + 32'h1000, 2'd3, 8'd1, INC);
    r_get(32'd0, 32'd0, 2, 1, 2'b11, 2'd3, 16'hFFFF, g);
    aw_send(BASE + 32'h1000, 2'd1, 8'd0, INC);
    w_send(32'hDEADBEEF, 32'd0, 1, 4'hF, 0, wst);
    b_get(2'd1, 2'b11);
    ar_send(BASE, 2'd0, 8'd0, INC);
    r_get(32'hCAFEF00D, 32'd0, 1, 0, 2'b00, 2'd0, 16'hFFFF, g);

    // Unsupported burst types.
    aw_send(BASE, 2'd1, 8'd0, 2'b10);
    w_send(32'h12345678, 32'd0, 1, 4'hF, 0, wst);
    b_get(2'd1, 2'b10);
    ar_send(BASE, 2'd2, 8'd0, 2'b11);
    r_get(32'd0, 32'd0, 1, 0, 2'b10, 2'd2, 16'hFFFF, g);
    ar_send(BASE, 2'd0, 8'd0, INC);
    r_get(32'hCAFEF00D, 32'd0, 1, 0, 2'b00, 2'd0, 16'hFFFF, g);

    // LAST on beat 1 of a 3-beat burst: all 3 beats taken, RESP=10.
    aw_send(BASE + 32'h80, 2'd3, 8'd2, INC);
    w_send(32'h50, 32'd1, 3, 4'hF, 1, wst);
    check("wready_drop", 64'(bus.WR_DATA_READY), 64'h0);
    b_get(2'd3, 2'b10);

    // 8-word preload, then read under irregular backpressure.
    aw_send(BASE + 32'h100, 2'd0, 8'd7, INC);
    w_send(32'h100, 32'd1, 8, 4'hF, 7, wst);
    b_get(2'd0, 2'b00);
    ar_send(BASE + 32'h100, 2'd2, 8'd7, INC);
    r_get(32'h100, 32'd1, 8, 7, 2'b00, 2'd2, 16'b1011_0010_0110_1001, g);

    // Reset while beat 4 of a read is pending.
    ar_send(BASE + 32'h100, 2'd1, 8'd7, INC);
    r_get(32'h100, 32'd1, 4, 99, 2'b00, 2'd1, 16'hFFFF, g);
    check("rvalid_beat4", 64'(bus.RD_DATA_VALID), 64'h1);
    rst = 1'b1;
    #1 check("outs_mid_reset", outs(), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("outs_mid_release", outs(), 64'h0);
    @(negedge clk);
    check("arready_after_abort", 64'(bus.RD_ADDR_READY), 64'h1);
    ar_send(BASE + 32'h40, 2'd2, 8'd0, INC);
    r_get(32'hAA22CC44, 32'd0, 1, 0, 2'b00, 2'd2, 16'hFFFF, g);

    // FIXED burst: the word keeps the last beat.
    aw_send(BASE + 32'h200, 2'd2, 8'd3, FIX);
    w_send(32'd5, 32'd1, 4, 4'hF, 3, wst);
    b_get(2'd2, 2'b00);
    ar_send(BASE + 32'h200, 2'd1, 8'd1, FIX);
    r_get(32'd8, 32'd0, 2, 1, 2'b00, 2'd1, 16'hFFFF, g);

    // Concurrent write and read at full rate.
    fork
      begin
        aw_send(BASE + 32'h300, 2'd1, 8'd3, INC);
        w_send(32'hA0, 32'd1, 4, 4'hF, 3, wst);
        b_get(2'd1, 2'b00);
      end
      begin
        ar_send(BASE + 32'h100, 2'd3, 8'd3, INC);
        r_get(32'h100, 32'd1, 4, 3, 2'b00, 2'd3, 16'hFFFF, rgp);
      end
    join
    check("w_full_rate", 64'(wst), 64'h0);
    check("r_full_rate", 64'(rgp), 64'h0);
    ar_send(BASE + 32'h300, 2'd0, 8'd3, INC);
    r_get(32'hA0, 32'd1, 4, 3, 2'b00, 2'd0, 16'hFFFF, g);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI responder that terminates the team's 32-bit `AXI_INF` bus on its slave side and backs it with on-chip word memory. It sits at an interconnect slave port as the default target for masters that need scratch RAM. It is also the reference responder the masters are verified against. Write and read channels run independently, support FIXED/INCR bursts up to 256 beats, echo IDs and report address/burst errors through the response codes.

## Interface
- `ID_WIDTH`, 2: must match the connected `AXI_INF` instance.
- `DEPTH_WORDS`, 1024: memory size in 32-bit words, power of two.
- `BASE_ADDR`, 32'h0000_0000: byte base address, aligned to `DEPTH_WORDS*4`.
- `CLK` input 1: sole clock, rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `S` modport `AXI_INF.SYNC_S`: all five AXI channels; the block drives every output in `SYNC_S` and never drives `CLK`/`RSTN` of the interface.

## Operation
- Address decode: `in_range = (ADDR - BASE_ADDR) < DEPTH_WORDS*4`; word index `= (ADDR - BASE_ADDR) >> 2`; `ADDR[1:0]` is ignored.
- Burst codes: 00 FIXED (index constant), 01 INCR (index +1 per beat, wraps modulo `DEPTH_WORDS`), 10/11 unsupported.
- Response codes: 00 OKAY; 10 error (unsupported burst, or `WR_DATA_LAST` disagrees with the beat count); 11 address out of range. The burst error takes priority over the range error.
- Write FSM `W_IDLE -> W_DATA -> W_RESP -> W_IDLE`:
  - `W_IDLE`: `WR_ADDR_READY`=1. On handshake, latch ID, index, LEN, BURST and error code.
  - `W_DATA`: `WR_DATA_READY`=1. Each handshake writes bytes where `WR_STRB[i]`=1, only if the latched code is 00. The beat counter ends the burst after LEN+1 beats regardless of `WR_DATA_LAST`. If `LAST` is high on an early beat or low on the final beat, the code becomes 10; writes already done stay.
  - `W_RESP`: `WR_BACK_VALID`=1 with latched ID/RESP, held until `WR_BACK_READY`.
- Read FSM `R_IDLE -> R_FETCH -> R_DATA -> R_IDLE`:
  - `R_IDLE`: `RD_ADDR_READY`=1. Latch as for writes.
  - `R_FETCH`: one cycle of RAM read.
  - `R_DATA`: `RD_DATA_VALID`=1. The RAM is read at the next index when a handshake occurs, otherwise at the current index, so `RD_DATA` is stable under backpressure.
  - Error bursts return `RD_DATA`=0 with the error code on every beat and still deliver LEN+1 beats.
  - `RD_DATA_LAST`=1 on beat LEN. After the last handshake, go to `R_IDLE`.
- Read/write collision on the same word in the same cycle: the read returns the old data.
- Memory contents are not reset.

## Timing
- While `RST`=1, and in the first cycle after release, all outputs are 0: READYs, VALIDs, LAST, ID, RESP, DATA.
- `RST` asserted mid-burst aborts both FSMs to IDLE immediately. No response is issued for the aborted burst.
- Write: AW handshake at cycle T; `WR_DATA_READY` from T+1; `WR_BACK_VALID` at the cycle after the final-beat handshake; `WR_ADDR_READY` again the cycle after the B handshake.
- Read: AR handshake at T; `RD_DATA_VALID` first at T+2; with `RD_DATA_READY` held high, one beat per cycle; `RD_ADDR_READY` again the cycle after the last handshake.
- Once VALID is asserted, it and its payload stay unchanged until the handshake.
- Only one outstanding burst per direction. The next AW/AR is not accepted until the current response completes.

## Structure
- Package `axi_slave_pkg`:
  - constants `BURST_FIXED/INCR`, `RESP_OKAY/ERR/DECERR`
  - enums `wr_state_t`, `rd_state_t`
- Sub-module `axi_ram_slave_mem`: simple dual-port RAM with one write port (4-bit byte enable) and one synchronous read port.

## Test plan
- INCR write addr `BASE+0x10`, LEN=3, data 1..4, STRB=F, then an INCR read of the same range -> read returns 1,2,3,4 with RESP 00, LAST only on beat 3, and the B channel returns the AW ID.
- Write 0xAABBCCDD, then write 0x11223344 with STRB=0101 to the same word -> readback 0xAA22CC44.
- Read at `BASE+DEPTH_WORDS*4` with LEN=1 -> 2 beats, DATA=0, RESP=11. A write to the same address -> B RESP=11 and memory unchanged.
- Write with BURST=10 -> RESP=10 and no memory change. Write with LEN=2 and LAST on beat 1 -> 3 beats accepted, RESP=10.
- Read LEN=7 with `RD_DATA_READY` toggled randomly -> DATA stable while stalled, 8 beats in order. Assert RST on beat 4 -> all outputs 0 next cycle, and a fresh AR is accepted after release.
- FIXED write of 4 beats 5,6,7,8 -> the word holds 8. A concurrent write and read on different addresses both complete at full rate.
